// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 interrupt sequencer.
package pic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK1 = 2'd2
    } state_t;

    localparam logic [2:0] ROT_AEOI_CLR = 3'b000;
    localparam logic [2:0] EOI_NS       = 3'b001;
    localparam logic [2:0] NOP          = 3'b010;
    localparam logic [2:0] EOI_SP       = 3'b011;
    localparam logic [2:0] ROT_AEOI_SET = 3'b100;
    localparam logic [2:0] ROT_NS       = 3'b101;
    localparam logic [2:0] SET_PRI      = 3'b110;
    localparam logic [2:0] ROT_SP       = 3'b111;

    localparam logic [2:0] SPUR_LVL = 3'd7;

    // Rank 0 is the highest priority: the level just after the lowest-priority one.
    function automatic logic [2:0] pri_rank(input logic [2:0] lvl, input logic [2:0] lp);
        return lvl - lp - 3'd1;
    endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Finds the highest-priority set bit, scanning upward from (lp+1) mod 8 with wrap.
module pic_priority_resolver
    import pic_pkg::*;
(
    input  logic [7:0] i_bits,
    input  logic [2:0] i_lp,
    output logic       o_found,
    output logic [2:0] o_level
);

    always_comb begin
        logic [2:0] idx;
        o_found = 1'b0;
        o_level = 3'd0;
        idx     = 3'd0;
        // Scan lowest priority first so the highest-priority hit is written last.
        for (int i = 7; i >= 0; i--) begin
            idx = i_lp + 3'(i + 1);
            if (i_bits[idx]) begin
                o_found = 1'b1;
                o_level = idx;
            end
        end
    end

endmodule

// File: rtl/pic_interrupt_sequencer.sv
// 8259 IRR/ISR ownership, priority arbitration, INTA sequencing and OCW2 execution.
module pic_interrupt_sequencer
    import pic_pkg::*;
#(
    parameter int NUM_IR = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IR-1:0] ir_req,
    input  logic [NUM_IR-1:0] mask,
    input  logic [4:0]        vector_base,
    input  logic              aeoi,
    input  logic              ocw2_wr,
    input  logic [2:0]        ocw2_cmd,
    input  logic [2:0]        ocw2_lvl,
    input  logic              inta_pulse,
    output logic              int_out,
    output logic [7:0]        vec_out,
    output logic              vec_oe,
    output logic [NUM_IR-1:0] irr,
    output logic [NUM_IR-1:0] isr
);

    state_t            r_state;
    logic              r_int;
    logic [7:0]        r_vec;
    logic              r_vec_oe;
    logic [2:0]        r_grant;
    logic              r_spur;
    logic [NUM_IR-1:0] r_irr;
    logic [NUM_IR-1:0] r_isr;
    logic [2:0]        r_lp;
    logic              r_rot_aeoi;

    state_t            w_state_n;
    logic              w_int_n;
    logic [7:0]        w_vec_n;
    logic              w_vec_oe_n;
    logic [2:0]        w_grant_n;
    logic              w_spur_n;
    logic [NUM_IR-1:0] w_irr_n;
    logic [NUM_IR-1:0] w_irr_clr;
    logic [NUM_IR-1:0] w_isr_n;
    logic [2:0]        w_lp_n;

    logic [NUM_IR-1:0] w_eoi_clr;
    logic [NUM_IR-1:0] w_isr_eoi;
    logic [2:0]        w_lp_ocw;
    logic              w_rot_ocw;

    logic              w_cand_found;
    logic [2:0]        w_cand_lvl;
    logic              w_hi_found;
    logic [2:0]        w_hi_lvl;
    logic              w_elig;

    // Fully nested: a candidate must strictly outrank every bit still in service.
    function automatic logic outranks_isr(input logic [7:0] isr_bits,
                                          input logic [2:0] lvl,
                                          input logic [2:0] lp);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (isr_bits[i] && (pri_rank(3'(i), lp) <= pri_rank(lvl, lp)))
                ok = 1'b0;
        end
        return ok;
    endfunction

    pic_priority_resolver u_irr_res (
        .i_bits  (r_irr & ~mask),
        .i_lp    (r_lp),
        .o_found (w_cand_found),
        .o_level (w_cand_lvl)
    );

    pic_priority_resolver u_isr_res (
        .i_bits  (r_isr),
        .i_lp    (r_lp),
        .o_found (w_hi_found),
        .o_level (w_hi_lvl)
    );

    always_comb begin
        w_eoi_clr = '0;
        w_lp_ocw  = r_lp;
        w_rot_ocw = r_rot_aeoi;
        if (ocw2_wr) begin
            case (ocw2_cmd)
                EOI_NS: if (w_hi_found) w_eoi_clr[w_hi_lvl] = 1'b1;
                EOI_SP: w_eoi_clr[ocw2_lvl] = 1'b1;
                ROT_NS: begin
                    if (w_hi_found) begin
                        w_eoi_clr[w_hi_lvl] = 1'b1;
                        w_lp_ocw            = w_hi_lvl;
                    end
                end
                ROT_SP: begin
                    w_eoi_clr[ocw2_lvl] = 1'b1;
                    w_lp_ocw            = ocw2_lvl;
                end
                SET_PRI:      w_lp_ocw  = ocw2_lvl;
                ROT_AEOI_SET: w_rot_ocw = 1'b1;
                ROT_AEOI_CLR: w_rot_ocw = 1'b0;
                default: ;
            endcase
        end
    end

    // EOI applies before any INTA action in the same cycle.
    assign w_isr_eoi = r_isr & ~w_eoi_clr;
    assign w_elig    = w_cand_found && outranks_isr(w_isr_eoi, w_cand_lvl, r_lp);

    always_comb begin
        w_state_n  = r_state;
        w_int_n    = r_int;
        w_vec_n    = r_vec;
        w_vec_oe_n = 1'b0;
        w_grant_n  = r_grant;
        w_spur_n   = r_spur;
        w_isr_n    = w_isr_eoi;
        w_irr_clr  = '0;
        w_lp_n     = w_lp_ocw;
        case (r_state)
            IDLE: begin
                if (w_elig) begin
                    w_state_n = REQ;
                    w_int_n   = 1'b1;
                end
            end
            REQ: begin
                if (inta_pulse) begin
                    w_state_n = ACK1;
                    w_int_n   = 1'b0;
                    if (w_elig) begin
                        w_grant_n             = w_cand_lvl;
                        w_spur_n              = 1'b0;
                        w_isr_n[w_cand_lvl]   = 1'b1;
                        w_irr_clr[w_cand_lvl] = 1'b1;
                    end else begin
                        w_grant_n = SPUR_LVL;
                        w_spur_n  = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_pulse) begin
                    w_state_n  = IDLE;
                    w_vec_n    = {vector_base, r_grant};
                    w_vec_oe_n = 1'b1;
                    if (aeoi && !r_spur) begin
                        w_isr_n[r_grant] = 1'b0;
                        if (r_rot_aeoi) w_lp_n = r_grant;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
        w_irr_n = ir_req & ~w_irr_clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_int      <= 1'b0;
            r_vec      <= 8'h00;
            r_vec_oe   <= 1'b0;
            r_grant    <= 3'd0;
            r_spur     <= 1'b0;
            r_irr      <= '0;
            r_isr      <= '0;
            r_lp       <= 3'd7;
            r_rot_aeoi <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_int      <= w_int_n;
            r_vec      <= w_vec_n;
            r_vec_oe   <= w_vec_oe_n;
            r_grant    <= w_grant_n;
            r_spur     <= w_spur_n;
            r_irr      <= w_irr_n;
            r_isr      <= w_isr_n;
            r_lp       <= w_lp_n;
            r_rot_aeoi <= w_rot_ocw;
        end
    end

    assign int_out = r_int;
    assign vec_out = r_vec;
    assign vec_oe  = r_vec_oe;
    assign irr     = r_irr;
    assign isr     = r_isr;

endmodule

// File: doc/pic_interrupt_sequencer.md
# pic_interrupt_sequencer

Synchronous interrupt sequencer and priority arbiter for the 8259 PIC. It owns the IRR and ISR registers and resolves priority among eight requesters, in fixed or rotating mode, honouring the mask. It raises INT toward the CPU, runs the two-pulse INTA acknowledge sequence, drives the vector byte, and executes OCW2 EOI/rotate commands. It sits between the request inputs and the control-logic block, which supplies the decoded ICW/OCW fields.

## Interface
- `NUM_IR`, 8: number of request lines; fixed at 8, present only for documentation.
- `clk`  in  1: single clock; all state changes on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `ir_req`  in  8: level-sensitive requests, already synchronised to `clk`.
- `mask`  in  8: OCW1 mask; bit=1 blocks that IR from resolution.
- `vector_base`  in  5: ICW2[7:3]; vector = {vector_base, level}.
- `aeoi`  in  1: auto-EOI mode from ICW4.
- `ocw2_wr`  in  1: one-cycle strobe; `ocw2_cmd`/`ocw2_lvl` valid.
- `ocw2_cmd`  in  3: R/SL/EOI field.
- `ocw2_lvl`  in  3: L2..L0 field.
- `inta_pulse`  in  1: one-cycle strobe per INTA falling edge, already synchronised.
- `int_out`  out  1: interrupt request to CPU.
- `vec_out`  out  8: vector byte; valid while `vec_oe`.
- `vec_oe`  out  1: vector drive enable.
- `irr`  out  8: interrupt request register.
- `isr`  out  8: in-service register.

## Operation
- Reset values: `irr`=0, `isr`=0, `int_out`=0, `vec_out`=0, `vec_oe`=0, lowest-priority register `lp`=7 (IR0 highest), `rot_aeoi`=0, state IDLE.
- IRR: bit sets each cycle `ir_req` is high. It clears only at the first INTA for the granted bit, or when `ir_req` drops while not granted.
- Priority order: starts at (lp+1) mod 8 and wraps. The candidate is the highest-priority bit of `irr & ~mask`. It is eligible only if it outranks every set ISR bit (fully nested).
- FSM states:
  - IDLE: when an eligible candidate exists, go to REQ and set `int_out`=1 on the next edge.
  - REQ: on `inta_pulse`, latch the current candidate as `grant`, set `isr[grant]`, clear `irr[grant]`, go to ACK1.
    - Spurious case: no candidate at that `inta_pulse`. Set `grant`=7, leave ISR unchanged, set the `spurious` flag.
  - ACK1: on `inta_pulse`, drive `vec_out`={vector_base,grant}, set `vec_oe`=1 for exactly one cycle, go to IDLE.
    - If `aeoi` and not spurious, clear `isr[grant]`.
    - If `rot_aeoi` is also set, `lp`=grant.
- `int_out` drops on the edge that captures the first `inta_pulse`.
- OCW2 commands, acting on `ocw2_wr`:
  - 001: non-specific EOI; clear the highest-priority set ISR bit.
  - 011: specific EOI; clear `isr[ocw2_lvl]`.
  - 101: rotate on non-specific EOI; clear that bit and set `lp` to it.
  - 111: rotate on specific EOI; clear `isr[ocw2_lvl]` and set `lp`=`ocw2_lvl`.
  - 110: set priority; `lp`=`ocw2_lvl`.
  - 100: `rot_aeoi`=1.
  - 000: `rot_aeoi`=0.
  - 010: no operation.
  - A non-specific EOI with ISR=0 is a no-op.

## Timing
- Request to `int_out` high: 2 cycles (IRR latch, then FSM register).
- `inta_pulse` during IDLE is ignored.
- `ocw2_wr` and `inta_pulse` in the same cycle: apply the EOI first, then the INTA action on the updated ISR. The granted bit is set after any clear.
- A higher-priority request during REQ does not re-raise `int_out`. The grant is decided at the first INTA, so the higher request wins if it is present then.
- Reset mid-sequence returns to IDLE immediately and clears all outputs.
- Mask change during REQ: if the candidate disappears, the sequence completes as spurious.

## Structure
- Package `pic_pkg` holds:
  - the state enum (IDLE, REQ, ACK1);
  - the OCW2 command constants (EOI_NS, EOI_SP, ROT_NS, ROT_SP, SET_PRI, ROT_AEOI_SET, ROT_AEOI_CLR, NOP);
  - the spurious level constant 3'd7.
- Sub-module `pic_priority_resolver` is combinational. It takes bits[7:0] and lp[2:0] and returns found and level[2:0]. It is instantiated twice: once for the IRR candidate and once for the highest ISR bit.

## Test plan
- Fixed priority: `ir_req`=0x24, `vector_base`=5'h08, mask=0. Two INTA pulses give `vec_out`=0x42, then `isr`=0x04. `int_out` stays low until EOI_NS, then re-asserts; the next vector is 0x45.
- Nesting: IR5 in service, IR2 raised. `int_out` asserts. After the vector, `isr`=0x24. EOI_NS clears bit 2 first.
- Rotation: ROT_NS after servicing IR3 gives `lp`=3. With `ir_req`=0x11, the vector is {base,4}.
- AEOI with `rot_aeoi`: `aeoi`=1 and ROT_AEOI_SET. Servicing IR6 leaves `isr`=0 after the second INTA and sets `lp`=6.
- Spurious: `ir_req` IR1 drops before the first INTA. `vec_out`={base,7}, ISR unchanged.
- Reset in ACK1: `rst` pulse gives `int_out`=0, `vec_oe`=0, `irr`=0, `isr`=0, FSM in IDLE.
